lhist_predictor: RTL and testbench

LHIST_PREDICTOR -- requirements
Module: lhist_predictor

---
 rtl/lhist_predictor_pkg.sv | 15 +
 rtl/lhist_predictor_if.sv | 27 ++
 rtl/lhist_predictor_sat_ctr_step.sv | 25 ++
 rtl/lhist_predictor.sv | 114 +++++++++++
 tb/tb_lhist_predictor.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lhist_predictor_pkg.sv
// Shared constants for the local-history branch predictor: default geometry
// and the counter reset value.
package lhist_predictor_pkg;

  localparam int DEF_LHT_ENTRIES = 32;
  localparam int DEF_HIST_BITS   = 5;
  localparam int DEF_CTR_BITS    = 2;
  localparam int DEF_STAT_BITS   = 32;

  // Weakly-not-taken: one below the counter midpoint.
  function automatic int ctr_init(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/lhist_predictor_if.sv
// Fetch/resolve bus of the local-history predictor. The core side drives
// PCs and outcomes; the predictor answers with directions and reports.
interface lhist_predictor_if;

  logic [1:0][63:0] if_pc;
  logic [1:0]       if_valid;
  logic [1:0]       pred_taken;
  logic [1:0]       pred_valid;

  logic [1:0][63:0] br_pc;
  logic [1:0]       br_taken;
  logic [1:0]       br_pred;
  logic [1:0]       br_valid;
  logic [1:0]       mispredict;
  logic [1:0]       mispredict_valid;

  modport master (
    output if_pc, if_valid, br_pc, br_taken, br_pred, br_valid,
    input  pred_taken, pred_valid, mispredict, mispredict_valid
  );

  modport slave (
    input  if_pc, if_valid, br_pc, br_taken, br_pred, br_valid,
    output pred_taken, pred_valid, mispredict, mispredict_valid
  );

endinterface

// File: rtl/lhist_predictor_sat_ctr_step.sv
// One saturating up/down step of a pattern-table counter. Two instances are
// chained so that a second update to the same counter sees the first.
module sat_ctr_step
  import lhist_predictor_pkg::*;
#(
  parameter int CTR_BITS = DEF_CTR_BITS
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr_next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  always_comb begin
    // NOTE: default assignment first so every path writes ctr_next and no latch is inferred.
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) ctr_next = ctr + 1'b1;
    end else if (ctr != '0) begin
      ctr_next = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/lhist_predictor.sv
// Two-wide local-history predictor: per-PC history table feeding a shared
// pattern table of saturating counters, trained by two in-order resolve slots.
module lhist_predictor
  import lhist_predictor_pkg::*;
#(
  parameter int LHT_ENTRIES = DEF_LHT_ENTRIES,
  parameter int HIST_BITS   = DEF_HIST_BITS,
  parameter int CTR_BITS    = DEF_CTR_BITS,
  parameter int STAT_BITS   = DEF_STAT_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  lhist_predictor_if.slave     bus,
  output logic [STAT_BITS-1:0] stat_pred,
  output logic [STAT_BITS-1:0] stat_mispred
);

  localparam int IDX_BITS    = $clog2(LHT_ENTRIES);
  localparam int PHT_ENTRIES = 1 << HIST_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

  logic [HIST_BITS-1:0] lht [LHT_ENTRIES];
  logic [CTR_BITS-1:0]  pht [PHT_ENTRIES];

  // Fetch side reads only registered tables, so resolves never bypass.
  logic [1:0][IDX_BITS-1:0] fetch_idx;
  logic [1:0]               fetch_on;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fetch_idx[i]      = bus.if_pc[i][IDX_BITS+1:2];
      fetch_on[i]       = bus.if_valid[i] & enable;
      bus.pred_valid[i] = fetch_on[i];
      bus.pred_taken[i] = fetch_on[i] & pht[lht[fetch_idx[i]]][CTR_BITS-1];
    end
  end

  logic [1:0]               train;
  logic [1:0]               mis;
  logic [1:0][IDX_BITS-1:0] res_idx;
  logic [HIST_BITS-1:0]     hist0, hist0_next, hist1, hist1_next;
  logic [CTR_BITS-1:0]      ctr0, ctr0_next, ctr1, ctr1_next;

  assign train      = bus.br_valid & {2{enable}};
  assign mis        = train & (bus.br_taken ^ bus.br_pred);
  assign res_idx[0] = bus.br_pc[0][IDX_BITS+1:2];
  assign res_idx[1] = bus.br_pc[1][IDX_BITS+1:2];

  // Slot 0 works from table state.
  assign hist0      = lht[res_idx[0]];
  assign hist0_next = {hist0[HIST_BITS-2:0], bus.br_taken[0]};
  assign ctr0       = pht[hist0];

  // Slot 1 sees slot 0's updated history and counter when they collide.
  assign hist1      = (train[0] && res_idx[1] == res_idx[0]) ? hist0_next : lht[res_idx[1]];
  assign hist1_next = {hist1[HIST_BITS-2:0], bus.br_taken[1]};
  assign ctr1       = (train[0] && hist1 == hist0) ? ctr0_next : pht[hist1];

  sat_ctr_step #(.CTR_BITS(CTR_BITS)) u_step0 (
    .ctr      (ctr0),
    .taken    (bus.br_taken[0]),
    .ctr_next (ctr0_next)
  );

  sat_ctr_step #(.CTR_BITS(CTR_BITS)) u_step1 (
    .ctr      (ctr1),
    .taken    (bus.br_taken[1]),
    .ctr_next (ctr1_next)
  );

  logic [1:0]           n_pred, n_mis;
  logic [STAT_BITS:0]   sum_pred, sum_mis;

  assign n_pred   = {1'b0, train[0]} + {1'b0, train[1]};
  assign n_mis    = {1'b0, mis[0]} + {1'b0, mis[1]};
  assign sum_pred = {1'b0, stat_pred} + {{(STAT_BITS-1){1'b0}}, n_pred};
  assign sum_mis  = {1'b0, stat_mispred} + {{(STAT_BITS-1){1'b0}}, n_mis};

  // NOTE: all state here uses non-blocking assignments; when both slots write the
  // same entry the later (slot 1) assignment wins, and it already folds in slot 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the tables are flops, not RAM, because every entry must reset to a known value.
      for (int i = 0; i < LHT_ENTRIES; i++) lht[i] <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= CTR_INIT;
      bus.mispredict       <= '0;
      bus.mispredict_valid <= '0;
      stat_pred            <= '0;
      stat_mispred         <= '0;
    end else begin
      if (train[0]) begin
        lht[res_idx[0]] <= hist0_next;
        pht[hist0]      <= ctr0_next;
      end
      if (train[1]) begin
        lht[res_idx[1]] <= hist1_next;
        pht[hist1]      <= ctr1_next;
      end
      bus.mispredict       <= mis;
      bus.mispredict_valid <= train;
      stat_pred            <= sum_pred[STAT_BITS] ? '1 : sum_pred[STAT_BITS-1:0];
      stat_mispred         <= sum_mis[STAT_BITS]  ? '1 : sum_mis[STAT_BITS-1:0];
    end
  end

  // PC bits outside the table index carry no information for this predictor.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc[0][63:IDX_BITS+2], bus.if_pc[0][1:0],
                            bus.if_pc[1][63:IDX_BITS+2], bus.if_pc[1][1:0],
                            bus.br_pc[0][63:IDX_BITS+2], bus.br_pc[0][1:0],
                            bus.br_pc[1][63:IDX_BITS+2], bus.br_pc[1][1:0]};

endmodule

// File: tb/tb_lhist_predictor.sv
// Scoreboard bench for lhist_predictor: a behavioural model predicts each
// cycle's directions and reports, which are queued and compared as they appear.
module tb_lhist_predictor;

  localparam int SB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [SB-1:0] stat_pred, stat_mispred;

  lhist_predictor_if bus ();

  lhist_predictor #(
    .LHT_ENTRIES (32),
    .HIST_BITS   (5),
    .CTR_BITS    (2),
    .STAT_BITS   (SB)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .enable       (enable),
    .bus          (bus),
    .stat_pred    (stat_pred),
    .stat_mispred (stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] pv;
    logic [1:0] pt;
  } pred_exp_t;

  typedef struct packed {
    logic [1:0]    mis;
    logic [1:0]    misv;
    logic [SB-1:0] sp;
    logic [SB-1:0] sm;
  } rep_exp_t;

  pred_exp_t     pred_q[$];
  rep_exp_t      rep_q[$];
  logic [4:0]    lht_m [32];
  logic [1:0]    pht_m [32];
  logic [SB-1:0] sp_m, sm_m;
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [4:0] idx_of(input logic [63:0] pc);
    return pc[6:2];
  endfunction

  function automatic logic [SB-1:0] sat_add(input logic [SB-1:0] v, input int n);
    int s;
    s = int'(v) + n;
    return (s > (1 << SB) - 1) ? '1 : SB'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      lht_m[i] = 5'd0;
      pht_m[i] = 2'd1;
    end
    sp_m = '0;
    sm_m = '0;
  endtask

  // One clock of stimulus; expectations are pushed at drive time and popped
  // when the combinational and registered outputs become observable.
  task automatic cycle(input logic rst, input logic en,
                       input logic [1:0] fv, input logic [63:0] fpc0, input logic [63:0] fpc1,
                       input logic [1:0] bv, input logic [1:0] bt, input logic [1:0] bp,
                       input logic [63:0] bpc0, input logic [63:0] bpc1);
    pred_exp_t   pe, pg;
    rep_exp_t    re, rg;
    logic [63:0] fpc [2];
    logic [63:0] bpc [2];
    logic [4:0]  h, ix;
    logic [1:0]  c;
    int          np, nm;
    fpc[0] = fpc0; fpc[1] = fpc1;
    bpc[0] = bpc0; bpc[1] = bpc1;
    @(negedge clk);
    reset        = rst;
    enable       = en;
    bus.if_valid = fv;
    bus.if_pc[0] = fpc0;
    bus.if_pc[1] = fpc1;
    bus.br_valid = bv;
    bus.br_taken = bt;
    bus.br_pred  = bp;
    bus.br_pc[0] = bpc0;
    bus.br_pc[1] = bpc1;
    for (int i = 0; i < 2; i++) begin
      pe.pv[i] = fv[i] & en;
      pe.pt[i] = pe.pv[i] & pht_m[lht_m[idx_of(fpc[i])]][1];
    end
    pred_q.push_back(pe);
    re = '0;
    if (rst) begin
      model_reset();
    end else begin
      np = 0;
      nm = 0;
      for (int i = 0; i < 2; i++) begin
        if (bv[i] && en) begin
          ix = idx_of(bpc[i]);
          h  = lht_m[ix];
          c  = pht_m[h];
          if (bt[i]) begin
            if (c != 2'd3) c = c + 2'd1;
          end else if (c != 2'd0) begin
            c = c - 2'd1;
          end
          pht_m[h]   = c;
          lht_m[ix]  = {h[3:0], bt[i]};
          re.misv[i] = 1'b1;
          re.mis[i]  = bt[i] ^ bp[i];
          np++;
          if (re.mis[i]) nm++;
        end
      end
      sp_m = sat_add(sp_m, np);
      sm_m = sat_add(sm_m, nm);
    end
    re.sp = sp_m;
    re.sm = sm_m;
    rep_q.push_back(re);

    #1;
    pg = pred_q.pop_front();
    n_cmp++;
    if ({bus.pred_valid, bus.pred_taken} !== {pg.pv, pg.pt}) begin
      n_bad++;
      $display("FAIL pred @%0t: got valid=%b taken=%b, want valid=%b taken=%b",
               $time, bus.pred_valid, bus.pred_taken, pg.pv, pg.pt);
    end

    @(posedge clk);
    #1;
    rg = rep_q.pop_front();
    n_cmp++;
    if ({bus.mispredict, bus.mispredict_valid, stat_pred, stat_mispred} !==
        {rg.mis, rg.misv, rg.sp, rg.sm}) begin
      n_bad++;
      $display("FAIL report @%0t: got mis=%b mv=%b sp=%0d sm=%0d, want mis=%b mv=%b sp=%0d sm=%0d",
               $time, bus.mispredict, bus.mispredict_valid, stat_pred, stat_mispred,
               rg.mis, rg.misv, rg.sp, rg.sm);
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 2'b00, 64'h0, 64'h0, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
  endtask

  task automatic test_reset();
    int bad_lht, bad_pht;
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b11, 2'b11, 2'b00, 64'h40, 64'h44);
    // Reset wins over training driven in the same cycle.
    cycle(1'b1, 1'b1, 2'b00, 64'h0, 64'h0, 2'b11, 2'b11, 2'b00, 64'h40, 64'h44);
    bad_lht = 0;
    bad_pht = 0;
    for (int i = 0; i < 32; i++) begin
      if (dut.lht[i] !== 5'd0) bad_lht++;
      if (dut.pht[i] !== 2'd1) bad_pht++;
    end
    n_cmp++;
    if (bad_lht != 0) begin
      n_bad++;
      $display("FAIL reset_lht: %0d entries nonzero, want 0", bad_lht);
    end
    n_cmp++;
    if (bad_pht != 0) begin
      n_bad++;
      $display("FAIL reset_pht: %0d counters not 1, want 0", bad_pht);
    end
    n_cmp++;
    if ({stat_pred, stat_mispred, bus.mispredict_valid} !== '0) begin
      n_bad++;
      $display("FAIL reset_regs: got sp=%0d sm=%0d mv=%b, want 0 0 00",
               stat_pred, stat_mispred, bus.mispredict_valid);
    end
  endtask

  task automatic test_fetch_enable();
    do_reset();
    cycle(1'b0, 1'b1, 2'b11, 64'h1234, 64'h40, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
    cycle(1'b0, 1'b0, 2'b11, 64'h40, 64'h44, 2'b11, 2'b11, 2'b00, 64'h40, 64'h44);
    n_cmp++;
    if ({dut.lht[16], dut.lht[17], dut.pht[0], stat_pred} !== {5'd0, 5'd0, 2'd1, 4'd0}) begin
      n_bad++;
      $display("FAIL disabled_untouched: got lht16=%b lht17=%b pht0=%0d sp=%0d, want 0 0 1 0",
               dut.lht[16], dut.lht[17], dut.pht[0], stat_pred);
    end
  endtask

  task automatic test_two_taken();
    do_reset();
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b01, 2'b01, 2'b01, 64'h40, 64'h0);
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b01, 2'b01, 2'b01, 64'h40, 64'h0);
    n_cmp++;
    if ({dut.lht[16], dut.pht[0], dut.pht[1]} !== {5'b00011, 2'd2, 2'd2}) begin
      n_bad++;
      $display("FAIL two_taken: got lht16=%b pht0=%0d pht1=%0d, want 00011 2 2",
               dut.lht[16], dut.pht[0], dut.pht[1]);
    end
    // History is now 3, whose counter is still at its reset value.
    cycle(1'b0, 1'b1, 2'b01, 64'h40, 64'h0, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
  endtask

  task automatic test_same_entry();
    do_reset();
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b11, 2'b01, 2'b00, 64'h40, 64'h40);
    n_cmp++;
    if ({dut.lht[16], dut.pht[0], dut.pht[1]} !== {5'b00010, 2'd2, 2'd0}) begin
      n_bad++;
      $display("FAIL same_entry: got lht16=%b pht0=%0d pht1=%0d, want 00010 2 0",
               dut.lht[16], dut.pht[0], dut.pht[1]);
    end
  endtask

  task automatic test_same_counter();
    do_reset();
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b11, 2'b11, 2'b11, 64'h40, 64'h80);
    n_cmp++;
    if (dut.pht[0] !== 2'd3) begin
      n_bad++;
      $display("FAIL same_counter: got pht0=%0d, want 3", dut.pht[0]);
    end
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b11, 2'b11, 2'b11, 64'h44, 64'h48);
    n_cmp++;
    if ({dut.pht[0], dut.lht[17], dut.lht[18]} !== {2'd3, 5'd1, 5'd1}) begin
      n_bad++;
      $display("FAIL counter_saturate: got pht0=%0d lht17=%b lht18=%b, want 3 00001 00001",
               dut.pht[0], dut.lht[17], dut.lht[18]);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b01, 2'b01, 2'b00, 64'h40, 64'h0);
    n_cmp++;
    if ({bus.mispredict[0], bus.mispredict_valid[0], stat_mispred, stat_pred} !==
        {1'b1, 1'b1, 4'd1, 4'd1}) begin
      n_bad++;
      $display("FAIL mispredict: got mis=%b mv=%b sm=%0d sp=%0d, want 1 1 1 1",
               bus.mispredict[0], bus.mispredict_valid[0], stat_mispred, stat_pred);
    end
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b10, 2'b00, 2'b00, 64'h0, 64'h44);
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
  endtask

  task automatic test_stat_saturate();
    do_reset();
    for (int k = 0; k < 7; k++)
      cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b11, 2'b11, 2'b00, 64'h40, 64'h44);
    n_cmp++;
    if (stat_pred !== 4'd14) begin
      n_bad++;
      $display("FAIL stat_preset: got sp=%0d, want 14", stat_pred);
    end
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b11, 2'b11, 2'b00, 64'h40, 64'h44);
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b11, 2'b11, 2'b00, 64'h40, 64'h44);
    n_cmp++;
    if ({stat_pred, stat_mispred} !== {4'hf, 4'hf}) begin
      n_bad++;
      $display("FAIL stat_saturate: got sp=%0d sm=%0d, want 15 15", stat_pred, stat_mispred);
    end
    cycle(1'b1, 1'b1, 2'b00, 64'h0, 64'h0, 2'b11, 2'b11, 2'b00, 64'h40, 64'h44);
    n_cmp++;
    if ({dut.lht[16], dut.lht[17], dut.pht[0], dut.pht[31], stat_pred, bus.mispredict_valid} !==
        {5'd0, 5'd0, 2'd1, 2'd1, 4'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL mid_reset: got lht16=%b lht17=%b pht0=%0d pht31=%0d sp=%0d mv=%b",
               dut.lht[16], dut.lht[17], dut.pht[0], dut.pht[31], stat_pred, bus.mispredict_valid);
    end
    cycle(1'b0, 1'b1, 2'b00, 64'h0, 64'h0, 2'b01, 2'b01, 2'b01, 64'h40, 64'h0);
    n_cmp++;
    if ({stat_pred, dut.lht[16]} !== {4'd1, 5'd1}) begin
      n_bad++;
      $display("FAIL resume_after_reset: got sp=%0d lht16=%b, want 1 00001", stat_pred, dut.lht[16]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pcs [4];
    int          bad;
    pcs[0] = 64'h40; pcs[1] = 64'h44; pcs[2] = 64'h80; pcs[3] = 64'h1040;
    do_reset();
    for (int k = 0; k < 150; k++) begin
      cycle(1'b0, ($urandom_range(0, 7) != 0),
            2'($urandom), pcs[$urandom_range(0, 3)], pcs[$urandom_range(0, 3)],
            2'($urandom), 2'($urandom), 2'($urandom),
            pcs[$urandom_range(0, 3)], pcs[$urandom_range(0, 3)]);
    end
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (dut.lht[i] !== lht_m[i] || dut.pht[i] !== pht_m[i]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL random_tables: %0d entries differ from model, want 0", bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    bus.if_valid = '0;
    bus.if_pc    = '0;
    bus.br_valid = '0;
    bus.br_taken = '0;
    bus.br_pred  = '0;
    bus.br_pc    = '0;
    model_reset();
    repeat (2) @(posedge clk);

    test_reset();
    test_fetch_enable();
    test_two_taken();
    test_same_entry();
    test_same_counter();
    test_mispredict();
    test_stat_saturate();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
